// File: rtl/sdram_addr_traversal_ring.sv
// Circular-buffer address generator over the SDRAM word space: write/read pointers,
// occupancy, overwrite-oldest, replay rewind and bank/row/column address split.
module sdram_addr_traversal_ring #(
    parameter int BA_W        = 2,
    parameter int ROW_W       = 13,
    parameter int COL_W       = 9,
    parameter int ORDER       = 0,
    parameter int REPLAY_W    = 5,
    parameter int REPLAY_STEP = 512
) (
    input  logic                         CLK_48MHZ,
    input  logic                         RESET,
    input  logic                         WR_ADV,
    input  logic                         RD_NEXT,
    input  logic                         REPLAY_REQ,
    input  logic [REPLAY_W-1:0]          REPLAY,
    output logic [BA_W-1:0]              BA_WRITE_OUT,
    output logic [ROW_W-1:0]             ROW_WRITE_OUT,
    output logic [COL_W-1:0]             COL_WRITE_OUT,
    output logic [BA_W-1:0]              BA_READ_OUT,
    output logic [ROW_W-1:0]             ROW_READ_OUT,
    output logic [COL_W-1:0]             COL_READ_OUT,
    output logic [BA_W+ROW_W+COL_W:0]    LEVEL,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         OVERRUN,
    output logic                         RD_UNDERFLOW
);
    localparam int AW = BA_W + ROW_W + COL_W;
    localparam int RW = AW + REPLAY_W + 1;
    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   level_reg, level_next;
    logic [AW:0]   hist_reg, hist_next;
    logic          empty_reg, full_reg;
    logic          overrun_reg, overrun_next;
    logic          underflow_reg, underflow_next;

    logic [RW-1:0] replay_req_words;
    logic [RW-1:0] replay_avail;
    logic [RW-1:0] replay_amt;
    logic [AW-1:0] rd_after_replay, rd_after_read;
    logic [AW:0]   level_after_replay, level_after_read;

    always_comb begin
        replay_req_words   = RW'(REPLAY) * RW'(REPLAY_STEP);
        // Only words still held in memory but already read may be re-exposed.
        replay_avail       = RW'(hist_reg - level_reg);
        replay_amt         = (replay_req_words < replay_avail) ? replay_req_words : replay_avail;

        rd_after_replay    = rd_ptr_reg;
        level_after_replay = level_reg;
        if (REPLAY_REQ) begin
            rd_after_replay    = rd_ptr_reg - replay_amt[AW-1:0];
            level_after_replay = level_reg + replay_amt[AW:0];
        end

        rd_after_read    = rd_after_replay;
        level_after_read = level_after_replay;
        underflow_next   = 1'b0;
        if (RD_NEXT && !REPLAY_REQ) begin
            if (level_after_replay == '0) begin
                underflow_next = 1'b1;
            end else begin
                rd_after_read    = rd_after_replay + PTR_ONE;
                level_after_read = level_after_replay - LVL_ONE;
            end
        end

        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_after_read;
        level_next   = level_after_read;
        hist_next    = hist_reg;
        overrun_next = overrun_reg;
        if (WR_ADV) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            hist_next   = (hist_reg == DEPTH) ? hist_reg : hist_reg + LVL_ONE;
            if (level_after_read == DEPTH) begin
                rd_ptr_next  = rd_after_read + PTR_ONE;
                overrun_next = 1'b1;
            end else begin
                level_next = level_after_read + LVL_ONE;
            end
        end
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            hist_reg      <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            hist_reg      <= hist_next;
            empty_reg     <= (level_next == '0);
            full_reg      <= (level_next == DEPTH);
            overrun_reg   <= overrun_next;
            underflow_reg <= underflow_next;
        end
    end

    assign LEVEL        = level_reg;
    assign EMPTY        = empty_reg;
    assign FULL         = full_reg;
    assign OVERRUN      = overrun_reg;
    assign RD_UNDERFLOW = underflow_reg;

    generate
        if (ORDER == 0) begin : g_row_fastest
            assign BA_WRITE_OUT  = wr_ptr_reg[AW-1 -: BA_W];
            assign COL_WRITE_OUT = wr_ptr_reg[AW-BA_W-1 -: COL_W];
            assign ROW_WRITE_OUT = wr_ptr_reg[ROW_W-1:0];
            assign BA_READ_OUT   = rd_ptr_reg[AW-1 -: BA_W];
            assign COL_READ_OUT  = rd_ptr_reg[AW-BA_W-1 -: COL_W];
            assign ROW_READ_OUT  = rd_ptr_reg[ROW_W-1:0];
        end else begin : g_col_fastest
            assign BA_WRITE_OUT  = wr_ptr_reg[AW-1 -: BA_W];
            assign ROW_WRITE_OUT = wr_ptr_reg[AW-BA_W-1 -: ROW_W];
            assign COL_WRITE_OUT = wr_ptr_reg[COL_W-1:0];
            assign BA_READ_OUT   = rd_ptr_reg[AW-1 -: BA_W];
            assign ROW_READ_OUT  = rd_ptr_reg[AW-BA_W-1 -: ROW_W];
            assign COL_READ_OUT  = rd_ptr_reg[COL_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_sdram_addr_traversal_ring.sv
// Scoreboard bench: driver queues hand-computed expectations per cycle, monitor
// compares both address orderings after every clock edge.
module tb_sdram_addr_traversal_ring;
    localparam int BA_W = 1, ROW_W = 2, COL_W = 2, REPLAY_W = 3, REPLAY_STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, wr_adv = 1'b0, rd_next = 1'b0, replay_req = 1'b0;
    logic [2:0] replay_amt = 3'd0;

    logic [0:0] ba_w0, ba_r0, ba_w1, ba_r1;
    logic [1:0] row_w0, col_w0, row_r0, col_r0;
    logic [1:0] row_w1, col_w1, row_r1, col_r1;
    logic [5:0] level0, level1;
    logic empty0, full0, ovr0, udf0, empty1, full1, ovr1, udf1;

    typedef struct {
        int wr;
        int rd;
        int lvl;
        int ovr;
        int udf;
    } exp_t;
    exp_t exp_q[$];

    int compared = 0;
    int mismatched = 0;
    int txn = 0;

    always #5 clk = ~clk;

    sdram_addr_traversal_ring #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ORDER(0),
        .REPLAY_W(REPLAY_W), .REPLAY_STEP(REPLAY_STEP)) dut0 (
        .CLK_48MHZ(clk), .RESET(rst), .WR_ADV(wr_adv), .RD_NEXT(rd_next),
        .REPLAY_REQ(replay_req), .REPLAY(replay_amt),
        .BA_WRITE_OUT(ba_w0), .ROW_WRITE_OUT(row_w0), .COL_WRITE_OUT(col_w0),
        .BA_READ_OUT(ba_r0), .ROW_READ_OUT(row_r0), .COL_READ_OUT(col_r0),
        .LEVEL(level0), .EMPTY(empty0), .FULL(full0), .OVERRUN(ovr0), .RD_UNDERFLOW(udf0));

    sdram_addr_traversal_ring #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ORDER(1),
        .REPLAY_W(REPLAY_W), .REPLAY_STEP(REPLAY_STEP)) dut1 (
        .CLK_48MHZ(clk), .RESET(rst), .WR_ADV(wr_adv), .RD_NEXT(rd_next),
        .REPLAY_REQ(replay_req), .REPLAY(replay_amt),
        .BA_WRITE_OUT(ba_w1), .ROW_WRITE_OUT(row_w1), .COL_WRITE_OUT(col_w1),
        .BA_READ_OUT(ba_r1), .ROW_READ_OUT(row_r1), .COL_READ_OUT(col_r1),
        .LEVEL(level1), .EMPTY(empty1), .FULL(full1), .OVERRUN(ovr1), .RD_UNDERFLOW(udf1));

    function automatic void chk(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
        end
    endfunction

    // Drive one cycle of stimulus and queue the state expected after that edge.
    task automatic step(input logic s_rst, input logic s_wr, input logic s_rd,
                        input logic s_rq, input int s_amt,
                        input int e_wr, input int e_rd, input int e_lvl,
                        input int e_ovr, input int e_udf);
        exp_t e;
        @(negedge clk);
        rst        = s_rst;
        wr_adv     = s_wr;
        rd_next    = s_rd;
        replay_req = s_rq;
        replay_amt = 3'(s_amt);
        e.wr = e_wr; e.rd = e_rd; e.lvl = e_lvl; e.ovr = e_ovr; e.udf = e_udf;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("wr_ptr_order0", int'({ba_w0, col_w0, row_w0}), e.wr);
                chk("rd_ptr_order0", int'({ba_r0, col_r0, row_r0}), e.rd);
                chk("wr_ptr_order1", int'({ba_w1, row_w1, col_w1}), e.wr);
                chk("rd_ptr_order1", int'({ba_r1, row_r1, col_r1}), e.rd);
                chk("level0", int'(level0), e.lvl);
                chk("level1", int'(level1), e.lvl);
                chk("empty", int'(empty0), (e.lvl == 0) ? 1 : 0);
                chk("full", int'(full0), (e.lvl == 32) ? 1 : 0);
                chk("overrun", int'(ovr0), e.ovr);
                chk("underflow", int'(udf0), e.udf);
                chk("flags_order1", int'({empty1, full1, ovr1, udf1}),
                    int'({empty0, full0, ovr0, udf0}));
                $display("txn %0d: wr=%0d rd=%0d level=%0d empty=%0b full=%0b ovr=%0b udf=%0b",
                         txn, {ba_w0, col_w0, row_w0}, {ba_r0, col_r0, row_r0}, level0,
                         empty0, full0, ovr0, udf0);
            end
        end
    end

    initial begin : driver
        // Reset state, then three writes.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 0, i, 0, i, 0, 0);

        // Fill to full with wrap, then overwrite the oldest word.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 32; k++) step(0, 1, 0, 0, 0, k % 32, 0, k, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1, 32, 1, 0);

        // Underflow alone, then read+write on empty.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        // Write 20, read 18, then replays (clamped, RD_NEXT suppressed).
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) step(0, 1, 0, 0, 0, k, 0, k, 0, 0);
        for (int j = 1; j <= 18; j++) step(0, 0, 1, 0, 0, 20, j, 20 - j, 0, 0);
        step(0, 0, 0, 1, 3, 20, 6, 14, 0, 0);
        step(0, 0, 1, 1, 7, 20, 0, 20, 0, 0);
        step(0, 0, 1, 1, 0, 20, 0, 20, 0, 0);
        step(0, 0, 1, 0, 0, 20, 1, 19, 0, 0);

        // Refill to full, read+write while full, then overrun.
        for (int k = 1; k <= 13; k++) step(0, 1, 0, 0, 0, (20 + k) % 32, 1, 19 + k, 0, 0);
        step(0, 1, 1, 0, 0, 2, 2, 32, 0, 0);
        step(0, 1, 0, 0, 0, 3, 3, 32, 1, 0);

        // Reset wins over simultaneous strobes; replay afterwards has nothing to rewind.
        step(1, 1, 1, 1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 10; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sdram_addr_traversal_ring.md
Name: sdram_addr_traversal_ring

Overview:
- Parametrised successor to the SDRAM read-address counter. Keeps a write pointer and a read pointer into the SDRAM word space and treats that space as a circular buffer.
- Adds occupancy tracking, empty/full flags, overwrite-oldest on overrun, selectable address bit ordering and a replay (rewind) command.
- Sits between the sensor-data write path and the SDRAM controller / downlink read path; emits bank/row/column for both the next write and the next read.

Parameters:
- BA_W, 2, bank address width
- ROW_W, 13, row address width
- COL_W, 9, column address width
- ORDER, 0, linear-to-physical mapping: 0 = {BA,COL,ROW} (row fastest, legacy order); 1 = {BA,ROW,COL} (column fastest)
- REPLAY_W, 5, width of replay amount input
- REPLAY_STEP, 512, words rewound per replay unit (must be ≥1)
- Derived: AW = BA_W+ROW_W+COL_W; DEPTH = 2^AW

Ports:
- CLK_48MHZ  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- WR_ADV  in  1  one-cycle strobe: current write address consumed by the SDRAM writer
- RD_NEXT  in  1  one-cycle strobe: current read address consumed by the reader
- REPLAY_REQ  in  1  one-cycle strobe: rewind read pointer
- REPLAY  in  REPLAY_W  rewind amount, in units of REPLAY_STEP, sampled with REPLAY_REQ
- BA_WRITE_OUT / ROW_WRITE_OUT / COL_WRITE_OUT  out  BA_W / ROW_W / COL_W  next write address
- BA_READ_OUT / ROW_READ_OUT / COL_READ_OUT  out  BA_W / ROW_W / COL_W  next read address
- LEVEL  out  AW+1  unread words, 0..DEPTH
- EMPTY  out  1  LEVEL==0
- FULL  out  1  LEVEL==DEPTH
- OVERRUN  out  1  sticky: an unread word was overwritten
- RD_UNDERFLOW  out  1  one-cycle pulse: RD_NEXT arrived while EMPTY

Behaviour:
- Internal state:
  - wr_ptr, rd_ptr: AW bits each; wrap from DEPTH-1 to 0 by natural overflow
  - level: AW+1 bits
  - hist: AW+1 bits; words still retained in memory, saturates at DEPTH
- Address mapping:
  - ORDER=0: BA = ptr[AW-1 -: BA_W], COL = next COL_W bits, ROW = ptr[ROW_W-1:0]
  - ORDER=1: BA = top BA_W bits, ROW = next ROW_W bits, COL = ptr[COL_W-1:0]
- Outputs are registered. Every output reflects the state after the previous edge, so there is 1 cycle latency from a strobe to the new address.
- Reset (RESET=1 at an edge; wins over all strobes):
  - pointers, level and hist = 0; EMPTY=1, FULL=0, OVERRUN=0, RD_UNDERFLOW=0
  - all address outputs = 0
  - applies mid-operation; the next cycle behaves as freshly reset
- Per-cycle update, evaluated in this order:
  1. Replay, if REPLAY_REQ:
     - req = REPLAY*REPLAY_STEP, computed at AW+REPLAY_W+1 bits
     - amt = min(req, hist-level)
     - rd_ptr -= amt (modulo DEPTH); level += amt
     - RD_NEXT is ignored this cycle: no advance, no underflow pulse
  2. Read, if RD_NEXT and no replay:
     - if level (after step 1) == 0: no change, RD_UNDERFLOW=1 for one cycle
     - else rd_ptr+1, level-1
  3. Write, if WR_ADV:
     - wr_ptr+1; hist = min(hist+1, DEPTH)
     - if level (after steps 1–2) == DEPTH: rd_ptr+1 (drop oldest), level unchanged, OVERRUN←1
     - else level+1
- Consequences:
  - RD_NEXT and WR_ADV together, not empty: both pointers advance, level unchanged
  - both together, empty: read is underflow, write proceeds, level becomes 1
  - both together, full: read frees a slot, so no overrun
- OVERRUN clears only on RESET.
- Replay never exposes unwritten or overwritten words; amt=0 when hist==level.
- REPLAY=0 with REPLAY_REQ: no pointer change, but RD_NEXT is still suppressed.

Test Plan (bench parameters BA_W=1, ROW_W=2, COL_W=2, REPLAY_W=3, REPLAY_STEP=4 → DEPTH=32):
- Reset then 3 WR_ADV → write ptr 3, LEVEL=3, EMPTY=0. ORDER=0 gives ROW_WRITE_OUT=3, COL=0, BA=0. ORDER=1 gives COL_WRITE_OUT=3, ROW=0.
- 32 WR_ADV from reset → FULL=1, LEVEL=32, wr_ptr wrapped to 0, OVERRUN=0. A 33rd WR_ADV → OVERRUN=1, read ptr 1, LEVEL stays 32.
- From empty: RD_NEXT alone → RD_UNDERFLOW pulses 1 cycle, read ptr unchanged. RD_NEXT+WR_ADV together → LEVEL=1, read ptr unchanged.
- Write 20, read 18 (LEVEL=2), REPLAY_REQ with REPLAY=3 → amt=12, read ptr 6, LEVEL=14.
- Then REPLAY_REQ with REPLAY=7 → amt clamped to hist-level=6, read ptr 0, LEVEL=20. RD_NEXT asserted in the same cycle is ignored.
- RESET asserted while FULL with OVERRUN=1 → next cycle all outputs 0, EMPTY=1. A subsequent replay yields amt=0.
